cd_config_writer: RTL and testbench
===================================

# cd_config_writer

Initiator for the clock divider's configuration port. Drives `c_addr`/`c_data`/`c_valid` and watches `c_ready` to load VGA resolution and UART baud-rate limits: a default pair automatically after reset, then runtime update requests from the control logic. Uses a four-phase level handshake, so it is safe when the responder samples on a different, slower clock. Includes per-target pending slots, fixed priority, and a timeout.

## Interface
- `WIDTH_CONFIG_ADDR`, 2, config address width. Address 2'b01 selects UART and 2'b10 selects VGA.
- `WIDTH_CONFIG_DATA`, 8, config data width.
- `DEFAULT_VGA`, 8'd1, VGA data sent after reset.
- `DEFAULT_UART`, 8'd0, UART data sent after reset.
- `TIMEOUT`, 1024, maximum cycles allowed in each handshake phase.
- `WIDTH_TIMEOUT`, 10, timeout counter width; must satisfy 2^WIDTH_TIMEOUT >= TIMEOUT.

Ports:
- `clk`, in, 1, single clock. All logic is on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `req_vga`, in, 1, one-cycle pulse requesting a VGA config write.
- `vga_data`, in, WIDTH_CONFIG_DATA, resolution code, sampled when `req_vga`=1.
- `req_uart`, in, 1, one-cycle pulse requesting a UART config write.
- `uart_data`, in, WIDTH_CONFIG_DATA, baud code, sampled when `req_uart`=1.
- `c_addr`, out, WIDTH_CONFIG_ADDR, target address (registered).
- `c_data`, out, WIDTH_CONFIG_DATA, config value (registered).
- `c_valid`, out, 1, 1 = request is valid (registered).
- `c_ready`, in, 1, responder status: 0 = free, 1 = busy/acknowledging. Asynchronous to `clk`; double-flopped internally into `rdy_s`.
- `busy`, out, 1, 1 = a transaction is in flight or a slot is pending (registered).
- `done`, out, 1, one-cycle pulse when a write completes.
- `err`, out, 1, one-cycle pulse when a write is aborted by timeout.

## Operation
- Pending slots: `pend_vga`/`data_vga` and `pend_uart`/`data_uart`.
  - Reset sets both pending flags and loads them with `DEFAULT_VGA` and `DEFAULT_UART`.
  - A request pulse sets the slot and overwrites its data; the latest value wins.
  - A request arriving in the same cycle that its slot is consumed re-sets the slot, so the new value is sent afterwards.
- FSM states: IDLE, REQ, ACK.
  - IDLE → REQ when (`pend_vga` | `pend_uart`) and `rdy_s`=0. VGA has priority over UART. On this transition: load `c_addr`/`c_data` from the chosen slot, clear that slot's pending flag, set `c_valid`=1, clear the timeout counter.
  - REQ: hold `c_valid`, `c_addr` and `c_data` stable. When `rdy_s`=1: go to ACK, set `c_valid`=0, clear the timeout counter.
  - ACK: when `rdy_s`=0: pulse `done` and go to IDLE. `c_addr`/`c_data` keep their last values.
- Timeout: in REQ or ACK, when the counter reaches TIMEOUT-1:
  - pulse `err`, set `c_valid`=0, go to IDLE;
  - the transaction is dropped and its slot is not re-armed.
- If `rdy_s`=1 while in IDLE (e.g. the responder is still finishing an earlier write), wait; no timeout applies in IDLE.
- `busy` is registered: 1 when the next state ≠ IDLE or any pending flag is set next cycle.
- Reset, including mid-transaction:
  - IDLE, `c_valid`=0, `c_addr`=0, `c_data`=0, `done`=0, `err`=0, `busy`=0, counter=0;
  - both slots re-armed with defaults;
  - any in-flight write is abandoned.

## Timing
- Request pulse at cycle N, block IDLE, `rdy_s`=0: slot is set at N+1, and `c_valid`=1 from N+2 (one cycle for slot registration, one for the FSM).
- `c_ready` rising edge → `rdy_s` after 2 cycles → `c_valid` falls 1 cycle later: a 3-cycle response.
- `c_ready` falling → `done` high 3 cycles later, for exactly 1 cycle. The next transaction's `c_valid` can rise in the cycle after `done`.
- After `rst` falls (first cycle with `rst`=0 is cycle 0): `busy`=1 at cycle 1; the VGA default `c_valid` rises at cycle 1 if `rdy_s`=0.
- Timeout fires exactly TIMEOUT cycles after phase entry; `err` and `c_valid`=0 appear in the same cycle.

## Test plan
- Boot: release reset, responder model raises `c_ready` 4 cycles after `c_valid` and drops it 6 cycles later → VGA write (addr 2'b10, data 8'd1) then UART write (2'b01, 8'd0); exactly two `done` pulses; then `busy`=0.
- Single update: after boot, `req_uart` with `uart_data`=8'h2A → one write with addr 2'b01, data 8'h2A; `c_valid` rises 2 cycles after the pulse; one `done`.
- Priority and overwrite: `req_uart`=8'h05 and `req_vga`=8'h03 in the same cycle, then `req_uart`=8'h07 during the VGA write → VGA 8'h03 is sent first, then UART 8'h07 only; 8'h05 never appears.
- Timeout: responder holds `c_ready`=0 → `err` pulses TIMEOUT cycles after `c_valid` rises; `c_valid` drops; the next pending slot proceeds.
- Stuck busy: `c_ready` held at 1 after the acknowledge → `err` fires after TIMEOUT cycles in ACK; no `done`.
- Reset mid-REQ: assert `rst` while `c_valid`=1 → next cycle `c_valid`=0 and `busy`=0; after release the default VGA/UART sequence reruns.

Source files
------------

// File: rtl/cd_config_writer.sv
// Configuration-port initiator for the clock divider: sends default VGA/UART
// settings after reset, then runtime updates, over a four-phase level handshake.
module cd_config_writer #(
    parameter int WIDTH_CONFIG_ADDR = 2,
    parameter int WIDTH_CONFIG_DATA = 8,
    parameter logic [WIDTH_CONFIG_DATA-1:0] DEFAULT_VGA  = 8'd1,
    parameter logic [WIDTH_CONFIG_DATA-1:0] DEFAULT_UART = 8'd0,
    parameter int TIMEOUT       = 1024,
    parameter int WIDTH_TIMEOUT = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_vga,
    input  logic [WIDTH_CONFIG_DATA-1:0] vga_data,
    input  logic                         req_uart,
    input  logic [WIDTH_CONFIG_DATA-1:0] uart_data,
    output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    output logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_valid,
    input  logic                         c_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_UART = WIDTH_CONFIG_ADDR'(1);
    localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_VGA  = WIDTH_CONFIG_ADDR'(2);
    localparam logic [WIDTH_TIMEOUT-1:0]     CNT_LAST  = WIDTH_TIMEOUT'(TIMEOUT - 1);

    logic [1:0]                   state, state_nxt;
    logic [WIDTH_TIMEOUT-1:0]     cnt, cnt_nxt;
    logic                         pend_vga, pend_vga_nxt;
    logic                         pend_uart, pend_uart_nxt;
    logic [WIDTH_CONFIG_DATA-1:0] data_vga, data_vga_nxt;
    logic [WIDTH_CONFIG_DATA-1:0] data_uart, data_uart_nxt;
    logic [WIDTH_CONFIG_ADDR-1:0] addr_nxt;
    logic [WIDTH_CONFIG_DATA-1:0] cdata_nxt;
    logic                         valid_nxt, done_nxt, err_nxt, busy_nxt;
    logic                         rdy_m, rdy_s;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pend_vga_nxt  = pend_vga;
        pend_uart_nxt = pend_uart;
        data_vga_nxt  = data_vga;
        data_uart_nxt = data_uart;
        addr_nxt      = c_addr;
        cdata_nxt     = c_data;
        valid_nxt     = c_valid;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            IDLE: begin
                // A responder still finishing an older write keeps rdy_s high; wait it out.
                if ((pend_vga || pend_uart) && !rdy_s) begin
                    if (pend_vga) begin
                        addr_nxt     = ADDR_VGA;
                        cdata_nxt    = data_vga;
                        pend_vga_nxt = 1'b0;
                    end else begin
                        addr_nxt      = ADDR_UART;
                        cdata_nxt     = data_uart;
                        pend_uart_nxt = 1'b0;
                    end
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (rdy_s) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ACK;
                end else if (cnt == CNT_LAST) begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ACK: begin
                if (!rdy_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        // Requests are applied after slot consumption so a same-cycle request re-arms the slot.
        if (req_vga) begin
            pend_vga_nxt = 1'b1;
            data_vga_nxt = vga_data;
        end
        if (req_uart) begin
            pend_uart_nxt = 1'b1;
            data_uart_nxt = uart_data;
        end

        busy_nxt = (state_nxt != IDLE) || pend_vga_nxt || pend_uart_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_vga  <= 1'b1;
            pend_uart <= 1'b1;
            data_vga  <= DEFAULT_VGA;
            data_uart <= DEFAULT_UART;
            c_addr    <= '0;
            c_data    <= '0;
            c_valid   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            rdy_m     <= 1'b0;
            rdy_s     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_vga  <= pend_vga_nxt;
            pend_uart <= pend_uart_nxt;
            data_vga  <= data_vga_nxt;
            data_uart <= data_uart_nxt;
            c_addr    <= addr_nxt;
            c_data    <= cdata_nxt;
            c_valid   <= valid_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
            rdy_m     <= c_ready;
            rdy_s     <= rdy_m;
        end
    end

endmodule

// File: tb/tb_cd_config_writer.sv
// Scoreboard bench for cd_config_writer with a behavioural four-phase responder.
module tb_cd_config_writer;

    localparam int TIMEOUT = 1024;
    localparam int M_NORMAL = 0;
    localparam int M_SILENT = 1;
    localparam int M_STUCK  = 2;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic       is_err;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_vga, req_uart;
    logic [7:0] vga_data, uart_data;
    logic [1:0] c_addr;
    logic [7:0] c_data;
    logic       c_valid;
    logic       c_ready;
    logic       busy, done, err;

    sb_entry_t  sb[$];
    int         compared = 0;
    int         mismatched = 0;
    int         cyc = 0;
    int         resp_mode = M_NORMAL;
    int         wait_cnt = 0;
    int         hold_cnt = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    int         last_edge = 0;
    int         done_count = 0;
    int         err_count = 0;
    logic       prev_valid = 1'b0;
    logic [1:0] cap_addr = '0;
    logic [7:0] cap_data = '0;

    cd_config_writer dut (
        .clk(clk),
        .rst(rst),
        .req_vga(req_vga),
        .vga_data(vga_data),
        .req_uart(req_uart),
        .uart_data(uart_data),
        .c_addr(c_addr),
        .c_data(c_data),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pushExpected(input logic [1:0] addr, input logic [7:0] data, input logic is_err);
        sb_entry_t e;
        e.addr = addr;
        e.data = data;
        e.is_err = is_err;
        sb.push_back(e);
    endtask

    // Drives request pulses for exactly one cycle; called at a negedge.
    task automatic applyStimulus(input logic v, input logic u, input logic [7:0] vd, input logic [7:0] ud);
        req_vga   = v;
        vga_data  = vd;
        req_uart  = u;
        uart_data = ud;
        @(negedge clk);
        req_vga  = 1'b0;
        req_uart = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !busy && !c_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", n < budget, 1);
    endtask

    task automatic waitValid(input int budget);
        int n;
        n = 0;
        while (!c_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid_reached", n < budget, 1);
    endtask

    task automatic waitErr(input int budget);
        int n;
        n = 0;
        while (!err && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("err_reached", n < budget, 1);
    endtask

    // Responder: raises c_ready 4 cycles into c_valid, drops it 6 cycles later.
    always @(negedge clk) begin
        if (rst) begin
            c_ready  = 1'b0;
            wait_cnt = 0;
            hold_cnt = 0;
        end else if (resp_mode == M_SILENT) begin
            c_ready  = 1'b0;
            wait_cnt = 0;
        end else if (!c_ready) begin
            if (c_valid) begin
                wait_cnt++;
                if (wait_cnt == 4) begin
                    c_ready  = 1'b1;
                    rise_cyc = cyc;
                    wait_cnt = 0;
                    hold_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end else if (resp_mode == M_NORMAL) begin
            hold_cnt++;
            if (hold_cnt == 6) begin
                c_ready  = 1'b0;
                fall_cyc = cyc;
                hold_cnt = 0;
            end
        end
    end

    // Monitor: completes scoreboard entries on done/err and checks handshake latencies.
    always @(negedge clk) begin
        sb_entry_t e;
        if (rst) begin
            prev_valid = 1'b0;
            last_edge  = cyc;
        end else begin
            if (done || err) begin
                checkOutput("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("addr", cap_addr, e.addr);
                    checkOutput("data", cap_data, e.data);
                    checkOutput("kind_err", err, e.is_err);
                end
                if (done) begin
                    done_count++;
                    checkOutput("done_lat", cyc - fall_cyc, 3);
                end
                if (err) begin
                    err_count++;
                    checkOutput("err_lat", cyc - last_edge, TIMEOUT);
                    checkOutput("err_valid_low", c_valid, 0);
                end
            end
            if (c_valid && !prev_valid) begin
                cap_addr  = c_addr;
                cap_data  = c_data;
                last_edge = cyc;
            end
            if (!c_valid && prev_valid) begin
                last_edge = cyc;
                if (!err) begin
                    checkOutput("ack_lat", cyc - rise_cyc, 3);
                    checkOutput("hold_stable", {c_addr, c_data}, {cap_addr, cap_data});
                end
            end
            prev_valid = c_valid;
        end
    end

    initial begin
        int dc;
        rst = 1'b1;
        req_vga = 1'b0;
        req_uart = 1'b0;
        vga_data = '0;
        uart_data = '0;
        c_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", c_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_addr", c_addr, 0);
        checkOutput("rst_data", c_data, 0);
        checkOutput("rst_done_err", {done, err}, 0);

        // Boot: defaults VGA=1 then UART=0
        pushExpected(2'b10, 8'd1, 1'b0);
        pushExpected(2'b01, 8'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("boot_valid", c_valid, 1);
        checkOutput("boot_busy", busy, 1);
        checkOutput("boot_addr", c_addr, 2'b10);
        waitIdle(200);
        checkOutput("boot_done_count", done_count, 2);
        checkOutput("boot_busy_end", busy, 0);

        // Single update
        dc = done_count;
        pushExpected(2'b01, 8'h2A, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h2A);
        checkOutput("upd_valid_n1", c_valid, 0);
        checkOutput("upd_busy_n1", busy, 1);
        @(negedge clk);
        checkOutput("upd_valid_n2", c_valid, 1);
        checkOutput("upd_data_n2", c_data, 8'h2A);
        waitIdle(200);
        checkOutput("upd_done_count", done_count - dc, 1);

        // Priority and overwrite
        pushExpected(2'b10, 8'h03, 1'b0);
        pushExpected(2'b01, 8'h07, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h03, 8'h05);
        waitValid(20);
        checkOutput("prio_addr", c_addr, 2'b10);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h07);
        waitIdle(300);

        // Timeout in REQ, then the UART slot proceeds
        resp_mode = M_SILENT;
        dc = err_count;
        pushExpected(2'b10, 8'h11, 1'b1);
        pushExpected(2'b01, 8'h22, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h11, 8'h22);
        waitErr(TIMEOUT + 20);
        resp_mode = M_NORMAL;
        waitIdle(300);
        checkOutput("to_err_count", err_count - dc, 1);

        // Stuck busy: timeout in ACK, no done
        resp_mode = M_STUCK;
        dc = done_count;
        pushExpected(2'b10, 8'h33, 1'b0);
        sb[0].is_err = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h33, 8'h00);
        waitErr(TIMEOUT + 40);
        @(negedge clk);
        checkOutput("stuck_busy", busy, 0);
        hold_cnt = 0;
        resp_mode = M_NORMAL;
        waitIdle(100);
        checkOutput("stuck_no_done", done_count - dc, 0);

        // Reset mid-REQ
        resp_mode = M_SILENT;
        applyStimulus(1'b1, 1'b0, 8'h44, 8'h00);
        waitValid(20);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mrst_valid", c_valid, 0);
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_addr", c_addr, 0);
        sb.delete();
        pushExpected(2'b10, 8'd1, 1'b0);
        pushExpected(2'b01, 8'd0, 1'b0);
        resp_mode = M_NORMAL;
        dc = done_count;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mrst_rerun_valid", c_valid, 1);
        waitIdle(300);
        checkOutput("mrst_done_count", done_count - dc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
